load_register: RTL and testbench



---
 rtl/lab_pkg.sv | 9 +
 rtl/load_register.sv | 38 +++
 tb/tb_load_register.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lab_pkg.sv
// Shared constants for the lab datapath storage elements.
// Default data width and default reset word.
package lab_pkg;

  localparam int N_DEFAULT = 4;

  localparam logic [N_DEFAULT-1:0] RESET_DEFAULT = '0;

endpackage

// File: rtl/load_register.sv
// Parallel-load register with async reset, sync clear
// and a one-cycle strobe after each capture of d.
import lab_pkg::*;

module load_register #(
  parameter int             N           = N_DEFAULT,
  parameter logic [N-1:0]   RESET_VALUE = N'(RESET_DEFAULT)
) (
  output logic [N-1:0] q,
  input  logic [N-1:0] d,
  input  logic         ck,
  input  logic         load,
  input  logic         rst,
  input  logic         clr,
  output logic         loaded
);

  // Data word: clear beats load, load beats hold.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (clr) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

  // Strobe is high only in the cycle after d was captured.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      loaded <= 1'b0;
    end else begin
      loaded <= load && !clr;
    end
  end

endmodule

// File: tb/tb_load_register.sv
// Self-checking bench for load_register: directed plan
// followed by randomized traffic against a reference model.
module tb_load_register;

  localparam int N = 4;

  logic [N-1:0] q;
  logic [N-1:0] d;
  logic         ck;
  logic         load;
  logic         rst;
  logic         clr;
  logic         loaded;

  int pass_cnt;
  int total_cnt;

  // Reference state: what the register should hold now.
  logic [N-1:0] m_q;
  logic         m_loaded;

  load_register #(.N(N)) dut (
    .q      (q),
    .d      (d),
    .ck     (ck),
    .load   (load),
    .rst    (rst),
    .clr    (clr),
    .loaded (loaded)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Apply one edge's worth of inputs and check the result.
  task automatic step(input logic [N-1:0] dv,
                      input logic lv,
                      input logic cv,
                      input string tag);
    @(negedge ck);
    d    = dv;
    load = lv;
    clr  = cv;
    @(posedge ck);
    if (cv) begin
      m_q      = '0;
      m_loaded = 1'b0;
    end else if (lv) begin
      m_q      = dv;
      m_loaded = 1'b1;
    end else begin
      m_loaded = 1'b0;
    end
    #1;
    check({tag, ".q"}, 32'(q), 32'(m_q));
    check({tag, ".loaded"}, 32'(loaded), 32'(m_loaded));
  endtask

  // Pulse reset between edges and verify it acts without ck.
  task automatic mid_reset(input string tag);
    @(posedge ck);
    #2;
    rst = 1'b1;
    #1;
    m_q      = '0;
    m_loaded = 1'b0;
    check({tag, ".q"}, 32'(q), 32'(m_q));
    check({tag, ".loaded"}, 32'(loaded), 32'(m_loaded));
    #1;
    rst = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    m_q       = '0;
    m_loaded  = 1'b0;
    rst  = 1'b1;
    d    = '0;
    load = 1'b0;
    clr  = 1'b0;

    #1;
    check("reset.q", 32'(q), 32'h0);
    check("reset.loaded", 32'(loaded), 32'h0);

    @(negedge ck);
    rst = 1'b0;

    step(4'b0001, 1'b1, 1'b0, "load1");
    step(4'b0010, 1'b0, 1'b0, "hold_a");
    step(4'b0010, 1'b0, 1'b0, "hold_b");
    step(4'b0011, 1'b1, 1'b0, "reload");
    step(4'b0100, 1'b0, 1'b0, "ignore_a");
    step(4'b0101, 1'b0, 1'b0, "ignore_b");
    step(4'b1111, 1'b1, 1'b1, "clr_pri");
    step(4'b0011, 1'b1, 1'b0, "reload2");
    step(4'b0110, 1'b1, 1'b0, "track_a");
    step(4'b0111, 1'b1, 1'b0, "track_b");
    step(4'b0011, 1'b1, 1'b0, "track_c");
    mid_reset("async_rst");
    step(4'b1010, 1'b1, 1'b0, "post_rst");
    step(4'b1010, 1'b0, 1'b0, "post_hold");

    // Glitch on d and load between edges must not be seen.
    @(negedge ck);
    load = 1'b0;
    #1 d = 4'b0101;
    #1 load = 1'b1;
    #1 load = 1'b0;
    @(posedge ck);
    m_loaded = 1'b0;
    #1;
    check("glitch.q", 32'(q), 32'(m_q));
    check("glitch.loaded", 32'(loaded), 32'(m_loaded));

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        mid_reset("rnd_rst");
      end else begin
        step(N'($urandom),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0),
             "rnd");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
